// File: rtl/vga_rx_monitor_if.sv
// Bundle between a VGA PMOD source/controller and the receive monitor.
// Latency: none, wires only.
// Backpressure: none; the pixel stream is free-running and results are levels or pulses.
// Signals:
//   vga_in        raw PMOD pins: [7]=hsync [6]=b0 [5]=g0 [4]=r0 [3]=vsync [2]=b1 [1]=g1 [0]=r1
//   probe_x/y     probe coordinate (clocks after hsync lead / lines after frame start)
//   locked, h_total, h_sync_w, v_total, v_sync_w   lock state and timing measurements
//   frame_strobe, lock_lost, err_count             event pulses and lock-loss counter
//   probe_rgb, probe_valid                         sampled colour (RrGgBb) and its strobe
interface vga_rx_monitor_if #(
    parameter int CW = 11,
    parameter int VW = 10
);
    logic [7:0]    vga_in;
    logic [CW-1:0] probe_x;
    logic [VW-1:0] probe_y;
    logic          locked;
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_sync_w;
    logic [VW-1:0] v_total;
    logic [VW-1:0] v_sync_w;
    logic          frame_strobe;
    logic          lock_lost;
    logic [7:0]    err_count;
    logic [5:0]    probe_rgb;
    logic          probe_valid;

    // master: the side that produces the pixel stream and reads results
    modport master (
        output vga_in, probe_x, probe_y,
        input  locked, h_total, h_sync_w, v_total, v_sync_w,
        input  frame_strobe, lock_lost, err_count, probe_rgb, probe_valid
    );

    // slave: the monitor itself
    modport slave (
        input  vga_in, probe_x, probe_y,
        output locked, h_total, h_sync_w, v_total, v_sync_w,
        output frame_strobe, lock_lost, err_count, probe_rgb, probe_valid
    );
endinterface

// File: rtl/vga_rx_monitor.sv
// Watches a Tiny VGA PMOD stream, measures line/frame timing, locks, and probes one pixel.
// Latency: SYNC_STAGES+1 clocks from vga_in to probe_rgb; event pulses one clock after the edge.
// Backpressure: none; the stream is never stalled, all results are levels or one-cycle pulses.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous active-low reset, clears every register and output
//   io_bus   vga_rx_monitor_if.slave (pins and probe coordinate in, measurements/events out);
//            the interface instance must use the same CW/VW as this module.
module vga_rx_monitor #(
    parameter int CW              = 11,
    parameter int VW              = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    vga_rx_monitor_if.slave io_bus
);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Polarity is normalised before the synchroniser so that the reset value of
    // the flops (0) reads as "sync deasserted" and reset never fakes a sync edge.
    localparam logic [7:0] SYNC_POL = (SYNC_ACTIVE_LOW != 0) ? 8'h88 : 8'h00;

    logic [7:0] w_norm;
    logic [7:0] w_sync;

    assign w_norm = io_bus.vga_in ^ SYNC_POL;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = w_norm;
        end else begin : g_sync
            logic [7:0] r_sync [SYNC_STAGES];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= w_norm;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic       w_s_hs;
    logic       w_s_vs;
    logic [5:0] w_s_rgb;

    assign w_s_hs  = w_sync[7];
    assign w_s_vs  = w_sync[3];
    assign w_s_rgb = {w_sync[0], w_sync[4], w_sync[1], w_sync[5], w_sync[2], w_sync[6]};

    state_t        r_state;
    logic          r_hs_d;
    logic [CW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_vs_at_line;
    logic [VW-1:0] r_vs_cnt;
    logic          r_h_latched;
    logic [CW-1:0] r_h_total;
    logic [CW-1:0] r_h_sync_w;
    logic [VW-1:0] r_v_total;
    logic [VW-1:0] r_v_sync_w;
    logic          r_frame_strobe;
    logic          r_lock_lost;
    logic [7:0]    r_err_count;
    logic [5:0]    r_probe_rgb;
    logic          r_probe_valid;

    logic          w_hs_lead;
    logic          w_hs_trail;
    logic          w_hcnt_sat;
    logic [CW-1:0] w_hcnt_p1;
    logic [VW-1:0] w_frame_len;
    logic          w_frame_start;
    logic          w_probe_hit;

    assign w_hs_lead   = w_s_hs & ~r_hs_d;
    assign w_hs_trail  = ~w_s_hs & r_hs_d;
    assign w_hcnt_sat  = &r_hcnt;
    // hcnt is reloaded on the lead cycle itself, so it reads one less than the
    // number of clocks since the lead: +1 gives both line length (at the next
    // lead) and hsync pulse width in clocks (at the trail).
    assign w_hcnt_p1   = r_hcnt + CW'(1);
    assign w_frame_len = r_vcnt + VW'(1);
    assign w_frame_start = w_hs_lead & w_s_vs & ~r_vs_at_line;
    assign w_probe_hit = (r_state == LOCKED) &&
                         (r_vcnt == io_bus.probe_y) && (r_hcnt == io_bus.probe_x);

    // Next-state and measurement-load decode
    state_t w_state_nxt;
    logic   w_h_latched_nxt;
    logic   w_ld_h_total;
    logic   w_ld_h_sync_w;
    logic   w_ld_v;
    logic   w_lock_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_h_latched_nxt = r_h_latched;
        w_ld_h_total    = 1'b0;
        w_ld_h_sync_w   = 1'b0;
        w_ld_v          = 1'b0;
        w_lock_err      = 1'b0;
        case (r_state)
            SEEK: begin
                if (w_frame_start) begin
                    w_state_nxt     = MEASURE;
                    w_h_latched_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (w_hs_lead && r_h_latched && (w_hcnt_p1 != r_h_total)) begin
                    w_state_nxt = SEEK;
                end else begin
                    w_ld_h_sync_w = w_hs_trail;
                    if (w_frame_start) begin
                        // a frame with no complete line yet keeps measuring
                        if (r_h_latched) begin
                            w_ld_v      = 1'b1;
                            w_state_nxt = LOCKED;
                        end
                    end else if (w_hs_lead && !r_h_latched) begin
                        w_ld_h_total    = 1'b1;
                        w_h_latched_nxt = 1'b1;
                    end
                end
            end
            LOCKED: begin
                w_lock_err = (w_hs_lead && (w_hcnt_p1 != r_h_total)) ||
                             (w_frame_start && (w_frame_len != r_v_total)) ||
                             (w_hs_trail && (w_hcnt_p1 != r_h_sync_w)) ||
                             w_hcnt_sat;
                if (w_lock_err) w_state_nxt = SEEK;
            end
            default: w_state_nxt = SEEK;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SEEK;
            r_h_latched <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_h_latched <= w_h_latched_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs_d         <= 1'b0;
            r_hcnt         <= '0;
            r_vcnt         <= '0;
            r_vs_at_line   <= 1'b0;
            r_vs_cnt       <= '0;
            r_h_total      <= '0;
            r_h_sync_w     <= '0;
            r_v_total      <= '0;
            r_v_sync_w     <= '0;
            r_frame_strobe <= 1'b0;
            r_lock_lost    <= 1'b0;
            r_err_count    <= '0;
            r_probe_rgb    <= '0;
            r_probe_valid  <= 1'b0;
        end else begin
            r_hs_d <= w_s_hs;

            if (w_hs_lead)        r_hcnt <= '0;
            else if (!w_hcnt_sat) r_hcnt <= w_hcnt_p1;

            if (w_frame_start)               r_vcnt <= '0;
            else if (w_hs_lead && !(&r_vcnt)) r_vcnt <= r_vcnt + VW'(1);

            if (w_hs_lead) r_vs_at_line <= w_s_vs;

            // Lines with vsync asserted, counted from frame start; the line that
            // starts the frame is itself a vsync line.
            if (w_frame_start)                             r_vs_cnt <= VW'(1);
            else if (w_hs_lead && w_s_vs && !(&r_vs_cnt))  r_vs_cnt <= r_vs_cnt + VW'(1);

            if (w_ld_h_total)  r_h_total  <= w_hcnt_p1;
            if (w_ld_h_sync_w) r_h_sync_w <= w_hcnt_p1;
            if (w_ld_v) begin
                r_v_total  <= w_frame_len;
                r_v_sync_w <= r_vs_cnt;
            end

            r_frame_strobe <= w_frame_start;
            r_lock_lost    <= w_lock_err;
            if (w_lock_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;

            r_probe_valid <= w_probe_hit;
            if (w_probe_hit) r_probe_rgb <= w_s_rgb;
        end
    end

    assign io_bus.locked       = (r_state == LOCKED);
    assign io_bus.h_total      = r_h_total;
    assign io_bus.h_sync_w     = r_h_sync_w;
    assign io_bus.v_total      = r_v_total;
    assign io_bus.v_sync_w     = r_v_sync_w;
    assign io_bus.frame_strobe = r_frame_strobe;
    assign io_bus.lock_lost    = r_lock_lost;
    assign io_bus.err_count    = r_err_count;
    assign io_bus.probe_rgb    = r_probe_rgb;
    assign io_bus.probe_valid  = r_probe_valid;

endmodule
